// File: rtl/mux_2_1_arbiter.sv
// mux_2_1_arbiter
// Two-requester round-robin arbiter driving a shared DW-bit mux.
// The owner of the mux may transfer up to MAX_BURST words back to back
// while the other side is waiting. After that, ownership passes directly
// to the waiting requester with no idle cycle in between.
// All outputs are registered. gnt is one-hot-or-zero. S always names the
// current owner and keeps its last value while the arbiter is idle.

module mux_2_1_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [DW-1:0] in0,
    input  logic [DW-1:0] in1,
    output logic [1:0]    gnt,
    output logic          S,
    output logic [DW-1:0] out,
    output logic          out_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Counter value at which the transfer in progress is the last one
    // allowed in the current burst.
    localparam logic [7:0] LP_BURST_LAST = 8'(MAX_BURST - 1);

    state_t        r_state;
    logic [7:0]    r_cnt;
    logic          r_last;
    logic [1:0]    r_gnt;
    logic          r_s;
    logic [DW-1:0] r_out;
    logic          r_out_valid;

    logic          w_idle;
    logic          w_owner;
    logic          w_own_req;
    logic          w_other_req;
    logic          w_burst_done;
    logic          w_transfer;
    logic          w_take;
    logic          w_take_idx;
    logic          w_release;

    // Work out this cycle's decisions: is there a transfer, does ownership
    // move (and to whom), or does the current owner let go into idle.
    always_comb begin
        w_idle       = (r_state == ST_IDLE);
        w_owner      = (r_state == ST_OWN1);
        w_own_req    = req[w_owner];
        w_other_req  = req[~w_owner];
        w_burst_done = (r_cnt == LP_BURST_LAST);
        w_transfer   = 1'b0;
        w_take       = 1'b0;
        w_take_idx   = 1'b0;
        w_release    = 1'b0;
        if (w_idle) begin
            w_take     = (req != 2'b00);
            w_take_idx = (req == 2'b11) ? ~r_last : req[1];
        end else begin
            w_transfer = w_own_req;
            w_take     = w_other_req && (!w_own_req || w_burst_done);
            w_take_idx = ~w_owner;
            w_release  = !w_own_req && !w_other_req;
        end
    end

    // Arbitration state, burst counter, and registered mux outputs.
    // Reset takes precedence over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_last      <= 1'b1;
            r_gnt       <= 2'b00;
            r_s         <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_transfer) begin
                r_out       <= w_owner ? in1 : in0;
                r_out_valid <= 1'b1;
                r_cnt       <= r_cnt + 8'd1;
            end
            if (w_take) begin
                r_state <= w_take_idx ? ST_OWN1 : ST_OWN0;
                r_gnt   <= w_take_idx ? 2'b10 : 2'b01;
                r_s     <= w_take_idx;
                r_last  <= w_take_idx;
                r_cnt   <= 8'd0;
            end else if (w_release) begin
                r_state <= ST_IDLE;
                r_gnt   <= 2'b00;
            end else if (w_transfer && w_burst_done) begin
                r_cnt <= 8'd0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign S         = r_s;
    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule
